// File: rtl/wb_write_arbiter.sv
// Round-robin arbiter that shares two register-file write ports among six writeback units.
// Define WB_ARB_PERF_CNT_EN to add the stall_cnt_o performance counter.
module wb_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [5:0]              req_valid_i,
  input  logic [6*TAG_WIDTH-1:0]  req_tag_i,
  input  logic [6*DATA_WIDTH-1:0] req_data_i,
  output logic [5:0]              req_ready_o,
  output logic                    wr1_en_o,
  output logic [TAG_WIDTH-1:0]    wr1_addr_o,
  output logic [DATA_WIDTH-1:0]   wr1_data_o,
  output logic                    wr2_en_o,
  output logic [TAG_WIDTH-1:0]    wr2_addr_o,
  output logic [DATA_WIDTH-1:0]   wr2_data_o
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [15:0]             stall_cnt_o
`endif
);

  logic [2:0]            r_rr_ptr;
  logic [2:0]            w_idx;
  logic [2:0]            w_g1_idx;
  logic [2:0]            w_g2_idx;
  logic                  w_g1_vld;
  logic                  w_g2_seen;
  logic                  w_gnt1;
  logic                  w_gnt2;
  logic [TAG_WIDTH-1:0]  w_g1_tag;
  logic [TAG_WIDTH-1:0]  w_g2_tag;
  logic [DATA_WIDTH-1:0] w_g1_data;
  logic [DATA_WIDTH-1:0] w_g2_data;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'd6) s = s - 4'd6;
    return s[2:0];
  endfunction

  // Scan from the pointer: first valid is g1, second valid is the g2 candidate.
  always_comb begin
    w_idx     = '0;
    w_g1_idx  = '0;
    w_g2_idx  = '0;
    w_g1_vld  = 1'b0;
    w_g2_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w_idx = wrap_idx(r_rr_ptr, 3'(k));
      if (req_valid_i[w_idx]) begin
        if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1_idx = w_idx;
        end else if (!w_g2_seen) begin
          w_g2_seen = 1'b1;
          w_g2_idx  = w_idx;
        end
      end
    end
  end

  assign w_g1_tag  = req_tag_i[w_g1_idx*TAG_WIDTH +: TAG_WIDTH];
  assign w_g2_tag  = req_tag_i[w_g2_idx*TAG_WIDTH +: TAG_WIDTH];
  assign w_g1_data = req_data_i[w_g1_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_g2_data = req_data_i[w_g2_idx*DATA_WIDTH +: DATA_WIDTH];

  // A same-tag second winner is dropped rather than replaced by a third requester.
  assign w_gnt1 = w_g1_vld & ~flush_i & ~rst;
  assign w_gnt2 = w_gnt1 & w_g2_seen & (w_g2_tag != w_g1_tag);

  always_comb begin
    req_ready_o = '0;
    if (w_gnt1) req_ready_o[w_g1_idx] = 1'b1;
    if (w_gnt2) req_ready_o[w_g2_idx] = 1'b1;
  end

  // Output stage: write ports driven one cycle after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      wr1_en_o   <= 1'b0;
      wr1_addr_o <= '0;
      wr1_data_o <= '0;
      wr2_en_o   <= 1'b0;
      wr2_addr_o <= '0;
      wr2_data_o <= '0;
    end else begin
      wr1_en_o <= w_gnt1;
      wr2_en_o <= w_gnt2;
      if (w_gnt1) begin
        wr1_addr_o <= w_g1_tag;
        wr1_data_o <= w_g1_data;
      end
      if (w_gnt2) begin
        wr2_addr_o <= w_g2_tag;
        wr2_data_o <= w_g2_data;
        r_rr_ptr   <= wrap_idx(w_g2_idx, 3'd1);
      end else if (w_gnt1) begin
        r_rr_ptr   <= wrap_idx(w_g1_idx, 3'd1);
      end
    end
  end

`ifdef WB_ARB_PERF_CNT_EN
  logic w_stall;
  assign w_stall = |(req_valid_i & ~req_ready_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (w_stall && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based arbitration model.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [5:0]  req_valid_i;
  logic [35:0] req_tag_i;
  logic [191:0] req_data_i;
  logic [5:0]  req_ready_o;
  logic        wr1_en_o, wr2_en_o;
  logic [5:0]  wr1_addr_o, wr2_addr_o;
  logic [31:0] wr1_data_o, wr2_data_o;
`ifdef WB_ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] m_stall;
`endif

  logic [5:0]  tg [6];
  logic [31:0] dt [6];

  int total = 0;
  int bad = 0;

  int          m_ptr;
  logic [5:0]  m_ready;
  int          m_g1, m_g2;
  logic        m_h1, m_h2;
  logic        m_en1, m_en2;
  logic [5:0]  m_a1, m_a2;
  logic [31:0] m_d1, m_d2;
  logic [5:0]  seen_ready;

  wb_write_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_tag_i(req_tag_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .wr1_en_o(wr1_en_o), .wr1_addr_o(wr1_addr_o), .wr1_data_o(wr1_data_o),
    .wr2_en_o(wr2_en_o), .wr2_addr_o(wr2_addr_o), .wr2_data_o(wr2_data_o)
`ifdef WB_ARB_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    req_tag_i  = '0;
    req_data_i = '0;
    for (int i = 0; i < 6; i++) begin
      req_tag_i[i*6 +: 6]   = tg[i];
      req_data_i[i*32 +: 32] = dt[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Valid requesters listed in scan order from the pointer; first two are the candidates.
  task automatic model_arb();
    int order[$];
    m_ready = '0;
    m_h1 = 1'b0;
    m_h2 = 1'b0;
    m_g1 = 0;
    m_g2 = 0;
    for (int k = 0; k < 6; k++)
      if (req_valid_i[(m_ptr + k) % 6]) order.push_back((m_ptr + k) % 6);
    if (!flush_i && order.size() >= 1) begin
      m_h1 = 1'b1;
      m_g1 = order[0];
      m_ready[m_g1] = 1'b1;
      if (order.size() >= 2 && tg[order[1]] != tg[m_g1]) begin
        m_h2 = 1'b1;
        m_g2 = order[1];
        m_ready[m_g2] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_en1 = 0; m_en2 = 0;
    m_a1 = 0; m_a2 = 0;
    m_d1 = 0; m_d2 = 0;
`ifdef WB_ARB_PERF_CNT_EN
    m_stall = 0;
`endif
  endtask

  // One cycle: entered at posedge+1 with inputs driven, leaves at the next posedge+1.
  task automatic tick();
    #3;
    model_arb();
    seen_ready = req_ready_o;
    chk("ready", {58'd0, seen_ready}, {58'd0, m_ready});
`ifdef WB_ARB_PERF_CNT_EN
    if ((|(req_valid_i & ~m_ready)) && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
    @(posedge clk);
    #1;
    m_en1 = m_h1;
    m_en2 = m_h2;
    if (m_h1) begin m_a1 = tg[m_g1]; m_d1 = dt[m_g1]; end
    if (m_h2) begin m_a2 = tg[m_g2]; m_d2 = dt[m_g2]; end
    if (m_h2) m_ptr = (m_g2 + 1) % 6;
    else if (m_h1) m_ptr = (m_g1 + 1) % 6;
    chk("port1", {25'd0, wr1_en_o, wr1_addr_o, wr1_data_o}, {25'd0, m_en1, m_a1, m_d1});
    chk("port2", {25'd0, wr2_en_o, wr2_addr_o, wr2_data_o}, {25'd0, m_en2, m_a2, m_d2});
`ifdef WB_ARB_PERF_CNT_EN
    chk("stall_cnt", {48'd0, stall_cnt_o}, {48'd0, m_stall});
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    req_valid_i = 6'h3F;
    #2;
    chk("ready_in_reset", {58'd0, req_ready_o}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_outputs", {wr1_en_o, wr2_en_o, wr1_addr_o, wr2_addr_o, wr1_data_o},
        64'd0);
    rst = 1'b0;
    req_valid_i = '0;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    req_valid_i = '0;
    for (int i = 0; i < 6; i++) begin tg[i] = 6'(i + 10); dt[i] = 32'h1000 + i; end
    #1;

    // Single request
    do_reset();
    tg[2] = 6'd9; dt[2] = 32'hDEADBEEF;
    req_valid_i = 6'b000100;
    tick();
    chk("single_ready", {58'd0, seen_ready}, 64'b000100);
    chk("single_port1", {25'd0, wr1_en_o, wr1_addr_o, wr1_data_o}, {25'd0, 1'b1, 6'd9, 32'hDEADBEEF});
    chk("single_wr2_en", {63'd0, wr2_en_o}, 64'd0);
    chk("single_model_ptr", 64'(m_ptr), 64'd3);
    for (int i = 0; i < 6; i++) tg[i] = 6'(i + 10);
    req_valid_i = 6'h3F;
    tick();
    chk("after_single_ready", {58'd0, seen_ready}, 64'b011000);

    // Round-robin fairness
    do_reset();
    req_valid_i = 6'h3F;
    tick(); chk("rr0", {58'd0, seen_ready}, 64'b000011);
    tick(); chk("rr1", {58'd0, seen_ready}, 64'b001100);
    tick(); chk("rr2", {58'd0, seen_ready}, 64'b110000);
    tick(); chk("rr3", {58'd0, seen_ready}, 64'b000011);

    // Wrap from 5 to 0
    do_reset();
    req_valid_i = 6'b010000;
    tick();
    req_valid_i = 6'b100001;
    tick();
    chk("wrap_ready", {58'd0, seen_ready}, 64'b100001);
    chk("wrap_ports", {52'd0, wr1_addr_o, wr2_addr_o}, {52'd0, 6'd15, 6'd10});
    req_valid_i = 6'b000011;
    tick();
    chk("wrap_ptr1_addr", {58'd0, wr1_addr_o}, 64'd11);

    // Tag conflict
    do_reset();
    tg[0] = 6'd4; tg[1] = 6'd4; tg[2] = 6'd7;
    req_valid_i = 6'b000111;
    tick();
    chk("conflict_ready", {58'd0, seen_ready}, 64'b000001);
    chk("conflict_wr2_en", {63'd0, wr2_en_o}, 64'd0);
    req_valid_i = 6'b000110;
    tick();
    chk("conflict_retry", {58'd0, seen_ready}, 64'b000110);
    for (int i = 0; i < 6; i++) tg[i] = 6'(i + 10);

    // Flush
    req_valid_i = 6'h3F;
    flush_i = 1'b1;
    tick();
    chk("flush_ready", {58'd0, seen_ready}, 64'd0);
    chk("flush_en", {62'd0, wr1_en_o, wr2_en_o}, 64'd0);
    flush_i = 1'b0;
    tick();
    chk("post_flush_ready", {58'd0, seen_ready}, 64'b011000);

    // Asynchronous reset mid-cycle
    tick();
    chk("pre_areset_en", {63'd0, wr1_en_o}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_immediate", {62'd0, wr1_en_o, wr2_en_o}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid_i = 6'h3F;
    tick();
    chk("areset_restart", {58'd0, seen_ready}, 64'b000011);

    // Randomized requesters that hold until granted
    do_reset();
    for (int c = 0; c < 400; c++) begin
      flush_i = ($urandom_range(0, 9) == 0);
      tick();
      for (int i = 0; i < 6; i++)
        if (req_valid_i[i] && m_ready[i]) req_valid_i[i] = 1'b0;
      for (int i = 0; i < 6; i++)
        if (!req_valid_i[i] && $urandom_range(0, 2) != 0) begin
          req_valid_i[i] = 1'b1;
          tg[i] = 6'($urandom_range(0, 7));
          dt[i] = $urandom;
        end
    end
    flush_i = 1'b0;
    req_valid_i = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
